// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero r0, same-cycle write bypass, busy scoreboard and clear sweep FSM.
module regfile_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] w_in,
  input  logic             w_en,
  output logic             w_ready,
  input  logic [AW-1:0]    src0,
  input  logic [AW-1:0]    src1,
  output logic [WIDTH-1:0] op0,
  output logic [WIDTH-1:0] op1,
  output logic             src0_busy,
  output logic             src1_busy,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;

  logic sweeping;
  logic wr_acc;
  logic rsv_acc;
  logic fwd0, fwd1;

  assign sweeping = (state_q == StSweep);
  assign clr_busy = sweeping;
  assign w_ready  = !sweeping;
  assign clr_done = done_q;

  // Writes and reservations to a hardwired-zero r0 are discarded up front.
  assign wr_acc  = w_en && !sweeping && !(ZERO_REG && (dest == '0));
  assign rsv_acc = rsv_en && !sweeping && !(ZERO_REG && (rsv_addr == '0));

  // Forwarding is gated by reset so reads stay 0 while reset is held.
  assign fwd0 = BYPASS && reset && wr_acc && (dest == src0);
  assign fwd1 = BYPASS && reset && wr_acc && (dest == src1);

  // Read ports: zero register, then bypass, then stored contents.
  always_comb begin
    op0 = mem_q[src0];
    op1 = mem_q[src1];
    if (fwd0) op0 = w_in;
    if (fwd1) op1 = w_in;
    if (ZERO_REG && (src0 == '0)) op0 = '0;
    if (ZERO_REG && (src1 == '0)) op1 = '0;
  end

  // Busy flags: an in-flight writeback hides busy unless a new producer reserves it.
  always_comb begin
    src0_busy = busy_q[src0] && !(fwd0 && !(rsv_acc && (rsv_addr == src0)));
    src1_busy = busy_q[src1] && !(fwd1 && !(rsv_acc && (rsv_addr == src1)));
  end

  // Clear sweep next-state: one register per cycle, done pulse on return to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, sweep counter and done pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Register storage: sweep clearing takes priority over (blocked) writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (sweeping) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[dest] <= w_in;
    end
  end

  // Scoreboard: reservation is applied last so it wins over a same-address write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else if (sweeping) begin
      busy_q[cnt_q] <= 1'b0;
    end else begin
      if (wr_acc)  busy_q[dest]     <= 1'b0;
      if (rsv_acc) busy_q[rsv_addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (plain/bypass and zero-reg/no-bypass) driven
// in parallel, checked every cycle against an array-based model plus literal expectations.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  dest = '0, src0 = '0, src1 = '0, rsv_addr = '0;
  logic [15:0] w_in = '0;
  logic        w_en = 1'b0, rsv_en = 1'b0, clr_req = 1'b0;

  logic [15:0] op0_v [2];
  logic [15:0] op1_v [2];
  logic        s0b_v [2];
  logic        s1b_v [2];
  logic        wr_v  [2];
  logic        cb_v  [2];
  logic        cd_v  [2];

  always #5 clk = ~clk;

  regfile_param #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .dest(dest), .w_in(w_in), .w_en(w_en), .w_ready(wr_v[0]),
    .src0(src0), .src1(src1), .op0(op0_v[0]), .op1(op1_v[0]),
    .src0_busy(s0b_v[0]), .src1_busy(s1b_v[0]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(cb_v[0]), .clr_done(cd_v[0])
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .dest(dest), .w_in(w_in), .w_en(w_en), .w_ready(wr_v[1]),
    .src0(src0), .src1(src1), .op0(op0_v[1]), .op1(op1_v[1]),
    .src0_busy(s0b_v[1]), .src1_busy(s1b_v[1]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(cb_v[1]), .clr_done(cd_v[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit run_cmp  = 1'b0;

  // Model state; instance 0 has ZERO_REG=0/BYPASS=1, instance 1 has ZERO_REG=1/BYPASS=0.
  logic [15:0] m_mem  [2][8];
  logic        m_busy [2][8];
  int          m_left [2];
  int          m_pos  [2];
  logic        m_done [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic acc_w(input int k);
    return reset && w_en && (m_left[k] == 0) && !(k == 1 && dest == 3'd0);
  endfunction

  function automatic logic acc_r(input int k);
    return reset && rsv_en && (m_left[k] == 0) && !(k == 1 && rsv_addr == 3'd0);
  endfunction

  function automatic logic [15:0] exp_op(input int k, input logic [2:0] s);
    if (k == 1 && s == 3'd0) return 16'h0;
    if (k == 0 && acc_w(k) && dest == s) return w_in;
    return m_mem[k][s];
  endfunction

  function automatic logic exp_busy(input int k, input logic [2:0] s);
    return m_busy[k][s] && !(k == 0 && acc_w(k) && dest == s && !(acc_r(k) && rsv_addr == s));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]  = 16'h0;
        m_busy[k][i] = 1'b0;
      end
      m_left[k] = 0;
      m_pos[k]  = 0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_left[k] != 0) begin
          m_mem[k][m_pos[k]]  = 16'h0;
          m_busy[k][m_pos[k]] = 1'b0;
          m_pos[k]++;
          m_left[k]--;
          m_done[k] = (m_left[k] == 0);
        end else begin
          m_done[k] = 1'b0;
          if (acc_w(k)) begin
            m_mem[k][dest]  = w_in;
            m_busy[k][dest] = 1'b0;
          end
          if (acc_r(k)) m_busy[k][rsv_addr] = 1'b1;
          if (clr_req) begin
            m_left[k] = 8;
            m_pos[k]  = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.op0", k), 32'(op0_v[k]), 32'(exp_op(k, src0)));
        chk($sformatf("u%0d.op1", k), 32'(op1_v[k]), 32'(exp_op(k, src1)));
        chk($sformatf("u%0d.src0_busy", k), 32'(s0b_v[k]), 32'(exp_busy(k, src0)));
        chk($sformatf("u%0d.src1_busy", k), 32'(s1b_v[k]), 32'(exp_busy(k, src1)));
        chk($sformatf("u%0d.w_ready", k), 32'(wr_v[k]), 32'(m_left[k] == 0));
        chk($sformatf("u%0d.clr_busy", k), 32'(cb_v[k]), 32'(m_left[k] != 0));
        chk($sformatf("u%0d.clr_done", k), 32'(cd_v[k]), 32'(m_done[k]));
      end
    end
  end

  // Runs a sweep, tries a write in sweep cycle 3, counts busy cycles and done pulses.
  task automatic do_sweep(output int busy_cyc, output int done_cnt);
    busy_cyc = 0;
    done_cnt = 0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      w_en = 1'b0;
      if (cb_v[0]) begin
        busy_cyc++;
        if (busy_cyc == 3) begin
          w_en = 1'b1;
          dest = 3'd6;
          w_in = 16'hABCD;
        end
      end
      if (cd_v[0]) done_cnt++;
      step();
    end
    w_en = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      src0 = 3'(i);
      src1 = 3'(i);
      #1;
      chk({tag, ".a.op0"}, 32'(op0_v[0]), 32'h0);
      chk({tag, ".b.op1"}, 32'(op1_v[1]), 32'h0);
      chk({tag, ".a.busy"}, 32'(s0b_v[0]), 32'h0);
      step();
    end
  endtask

  int bc, dc, dn2;

  initial begin
    model_reset();
    #1 run_cmp = 1'b1;
    step();
    step();
    chk("rst.op0", 32'(op0_v[0]), 32'h0);
    chk("rst.w_ready", 32'(wr_v[0]), 32'h1);
    chk("rst.clr_busy", 32'(cb_v[0]), 32'h0);
    reset = 1'b1;
    step();

    // Write then read back.
    w_en = 1'b1; dest = 3'd5; w_in = 16'h1234;
    step();
    w_en = 1'b0; src0 = 3'd5; #1;
    chk("t1.a.op0", 32'(op0_v[0]), 32'h1234);
    chk("t1.b.op0", 32'(op0_v[1]), 32'h1234);
    src0 = 3'd1; #1;
    chk("t1.a.op0_r1", 32'(op0_v[0]), 32'h0);

    // Bypass versus no bypass.
    w_en = 1'b1; dest = 3'd3; w_in = 16'hBEEF; src1 = 3'd3; #1;
    chk("t2.a.op1_fwd", 32'(op1_v[0]), 32'hBEEF);
    chk("t2.b.op1_old", 32'(op1_v[1]), 32'h0);
    step();
    w_en = 1'b0; #1;
    chk("t2.b.op1_new", 32'(op1_v[1]), 32'hBEEF);

    // Zero register.
    w_en = 1'b1; dest = 3'd0; w_in = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd0;
    step();
    w_en = 1'b0; rsv_en = 1'b0; src0 = 3'd0; #1;
    chk("t3.b.op0", 32'(op0_v[1]), 32'h0);
    chk("t3.b.busy", 32'(s0b_v[1]), 32'h0);
    chk("t3.a.op0", 32'(op0_v[0]), 32'hFFFF);
    chk("t3.a.busy", 32'(s0b_v[0]), 32'h1);

    // Scoreboard.
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step();
    rsv_en = 1'b0; src0 = 3'd2; #1;
    chk("t4.a.busy_set", 32'(s0b_v[0]), 32'h1);
    chk("t4.b.busy_set", 32'(s0b_v[1]), 32'h1);
    w_en = 1'b1; dest = 3'd2; w_in = 16'h2222; rsv_en = 1'b1; rsv_addr = 3'd2; #1;
    chk("t4.a.busy_wr_rsv", 32'(s0b_v[0]), 32'h1);
    step();
    w_en = 1'b0; rsv_en = 1'b0; #1;
    chk("t4.a.busy_kept", 32'(s0b_v[0]), 32'h1);
    chk("t4.a.op0", 32'(op0_v[0]), 32'h2222);
    w_en = 1'b1; w_in = 16'h3333; #1;
    chk("t4.a.busy_masked", 32'(s0b_v[0]), 32'h0);
    chk("t4.b.busy_unmasked", 32'(s0b_v[1]), 32'h1);
    step();
    w_en = 1'b0; #1;
    chk("t4.a.busy_clr", 32'(s0b_v[0]), 32'h0);
    chk("t4.b.busy_clr", 32'(s0b_v[1]), 32'h0);
    chk("t4.b.op0", 32'(op0_v[1]), 32'h3333);

    // Fill, reserve, sweep.
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; dest = 3'(i); w_in = 16'h1001 + 16'(i);
      step();
    end
    w_en = 1'b0; rsv_en = 1'b1; rsv_addr = 3'd4;
    step();
    rsv_en = 1'b0; src0 = 3'd4; #1;
    chk("t5.a.busy4", 32'(s0b_v[0]), 32'h1);
    chk("t5.a.op4", 32'(op0_v[0]), 32'h1005);
    do_sweep(bc, dc);
    chk("t5.busy_cycles", 32'(bc), 32'd8);
    chk("t5.done_pulses", 32'(dc), 32'd1);
    all_zero("t5");

    // Reset in the middle of a sweep.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("t6.a.clr_busy", 32'(cb_v[0]), 32'h0);
    chk("t6.b.clr_busy", 32'(cb_v[1]), 32'h0);
    chk("t6.a.clr_done", 32'(cd_v[0]), 32'h0);
    step();
    reset = 1'b1;
    dn2 = 0;
    for (int c = 0; c < 4; c++) begin
      if (cd_v[0] || cd_v[1]) dn2++;
      step();
    end
    chk("t6.no_done", 32'(dn2), 32'd0);
    all_zero("t6");
    do_sweep(bc, dc);
    chk("t6.busy_cycles", 32'(bc), 32'd8);
    chk("t6.done_pulses", 32'(dc), 32'd1);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
